// File: rtl/alu_seq_pkg.sv
// Shared definitions for alu_seq: opcode map, FSM states and op classification.
// ALU_SEQ_MUL_EN marks opcode 0011 as an iterative multiply instead of illegal.
package alu_seq_pkg;

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_INC  = 4'b0010;
   localparam logic [3:0] OP_MUL  = 4'b0011;
   localparam logic [3:0] OP_SEQ  = 4'b0101;
   localparam logic [3:0] OP_ASL  = 4'b0110;
   localparam logic [3:0] OP_ASR  = 4'b0111;
   localparam logic [3:0] OP_NOT  = 4'b1000;
   localparam logic [3:0] OP_AND  = 4'b1001;
   localparam logic [3:0] OP_OR   = 4'b1010;
   localparam logic [3:0] OP_NAND = 4'b1011;
   localparam logic [3:0] OP_ROL  = 4'b1100;
   localparam logic [3:0] OP_ROR  = 4'b1101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUSY = 2'b01,
      ST_OUT  = 2'b10
   } state_t;

   function automatic logic is_shift(input logic [3:0] op);
      return (op == OP_ASL) || (op == OP_ASR) || (op == OP_ROL) || (op == OP_ROR);
   endfunction

   // Ops that may need the BUSY phase; shifts by 0 or 1 still finish at accept.
   function automatic logic is_iterative(input logic [3:0] op);
`ifdef ALU_SEQ_MUL_EN
      return is_shift(op) || (op == OP_MUL);
`else
      return is_shift(op);
`endif
   endfunction

endpackage

// File: rtl/alu_seq_comb.sv
// Single-cycle datapath of alu_seq: adder ops, logic ops, SEQ, zero-amount shift
// passthrough and their flags. Anything it does not implement is flagged illegal.
module alu_seq_comb #(
   parameter int WIDTH = 8
) (
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic             ovf,
   output logic             carry,
   output logic             illegal
);
   import alu_seq_pkg::*;

   localparam int MSB = WIDTH - 1;

   logic [WIDTH:0] sum_add;
   logic [WIDTH:0] sum_sub;
   logic [WIDTH:0] sum_inc;

   assign sum_add = {1'b0, a} + {1'b0, b};
   assign sum_sub = {1'b0, b} + {1'b0, ~a} + {{WIDTH{1'b0}}, 1'b1};
   assign sum_inc = {1'b0, a} + {{WIDTH{1'b0}}, 1'b1};

   // Overflow = carry into MSB xor carry out; carry-in to MSB recovered from the sum bit.
   always_comb begin
      result  = '0;
      ovf     = 1'b0;
      carry   = 1'b0;
      illegal = 1'b0;
      case (op)
         OP_ADD: begin
            result = sum_add[MSB:0];
            carry  = sum_add[WIDTH];
            ovf    = a[MSB] ^ b[MSB] ^ sum_add[MSB] ^ sum_add[WIDTH];
         end
         OP_SUB: begin
            result = sum_sub[MSB:0];
            carry  = sum_sub[WIDTH];
            ovf    = b[MSB] ^ ~a[MSB] ^ sum_sub[MSB] ^ sum_sub[WIDTH];
         end
         OP_INC: begin
            result = sum_inc[MSB:0];
            carry  = sum_inc[WIDTH];
            ovf    = a[MSB] ^ sum_inc[MSB] ^ sum_inc[WIDTH];
         end
         OP_SEQ:          result = {{(WIDTH-1){1'b0}}, (a == b)};
         OP_ASL, OP_ASR:  result = b;
         OP_ROL, OP_ROR:  result = a;
         OP_NOT:          result = ~a;
         OP_AND:          result = a & b;
         OP_OR:           result = a | b;
         OP_NAND:         result = ~(a & b);
`ifdef ALU_SEQ_MUL_EN
         OP_MUL:          result = '0;
`endif
         default:         illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with registered result/flags, iterative shift/rotate
// and, when ALU_SEQ_MUL_EN is defined, an iterative shift-add multiplier.
//   state | meaning
//   IDLE  | no result held, ready for an op
//   BUSY  | iterating a shift/rotate or multiply, one step per cycle
//   OUT   | result valid, waiting for out_ready
module alu_seq #(
   parameter int WIDTH = 8,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [SHW-1:0]   in_shamt,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_zero,
   output logic             out_neg,
   output logic             out_ovf,
   output logic             out_carry,
   output logic             out_illegal
);
   import alu_seq_pkg::*;

   localparam int CW = SHW + 1;

   // Returns {bit shifted out, shifted value} for a single 1-bit step.
   function automatic logic [WIDTH:0] shift_step(input logic [3:0] op,
                                                 input logic [WIDTH-1:0] v);
      logic [WIDTH:0] r;
      case (op)
         OP_ASL:  r = {v[WIDTH-1], v[WIDTH-2:0], 1'b0};
         OP_ASR:  r = {v[0], v[WIDTH-1], v[WIDTH-1:1]};
         OP_ROL:  r = {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
         OP_ROR:  r = {v[0], v[0], v[WIDTH-1:1]};
         default: r = {1'b0, v};
      endcase
      return r;
   endfunction

`ifdef ALU_SEQ_MUL_EN
   // One shift-add step: accumulator is {partial product high, remaining multiplier}.
   function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] acc_v,
                                                   input logic [WIDTH-1:0]   m);
      logic [WIDTH:0] s;
      s = {1'b0, acc_v[2*WIDTH-1:WIDTH]} + (acc_v[0] ? {1'b0, m} : '0);
      return {s, acc_v[WIDTH-1:1]};
   endfunction
`endif

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [3:0]       op_r;
   logic [WIDTH-1:0] sh_val;

   logic             accept;
   logic             start_busy;
   logic             load_out;

   logic [WIDTH-1:0] c_result;
   logic             c_ovf;
   logic             c_carry;
   logic             c_illegal;

   logic [WIDTH-1:0] sh_src;
   logic [WIDTH:0]   sh_first;
   logic [WIDTH:0]   sh_next;

   logic [WIDTH-1:0] ld_result;
   logic             ld_ovf;
   logic             ld_carry;
   logic             ld_illegal;

`ifdef ALU_SEQ_MUL_EN
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   mcand;
   logic [2*WIDTH-1:0] mul_first;
   logic [2*WIDTH-1:0] mul_next;

   assign mul_first = mul_step({{WIDTH{1'b0}}, in_b}, in_a);
   assign mul_next  = mul_step(acc, mcand);
`endif

   alu_seq_comb #(.WIDTH(WIDTH)) u_comb (
      .op      (in_op),
      .a       (in_a),
      .b       (in_b),
      .result  (c_result),
      .ovf     (c_ovf),
      .carry   (c_carry),
      .illegal (c_illegal)
   );

   assign in_ready = (state == ST_IDLE) || ((state == ST_OUT) && out_ready);
   assign accept   = in_valid && in_ready;

   // The accept edge already performs the first step, so BUSY lasts n-1 cycles.
   assign sh_src     = ((in_op == OP_ROL) || (in_op == OP_ROR)) ? in_a : in_b;
   assign sh_first   = shift_step(in_op, sh_src);
   assign sh_next    = shift_step(op_r, sh_val);
   assign start_busy = is_iterative(in_op) && ((in_op == OP_MUL) || (in_shamt > SHW'(1)));
   assign load_out   = (state == ST_BUSY) ? (cnt == CW'(1)) : (accept && !start_busy);

   always_comb begin
      ld_result  = c_result;
      ld_ovf     = c_ovf;
      ld_carry   = c_carry;
      ld_illegal = c_illegal;
      if (state == ST_BUSY) begin
         ld_result  = sh_next[WIDTH-1:0];
         ld_carry   = sh_next[WIDTH];
         ld_ovf     = 1'b0;
         ld_illegal = 1'b0;
`ifdef ALU_SEQ_MUL_EN
         if (op_r == OP_MUL) begin
            ld_result = mul_next[WIDTH-1:0];
            ld_ovf    = |mul_next[2*WIDTH-1:WIDTH];
            ld_carry  = 1'b0;
         end
`endif
      end else if (is_shift(in_op) && (in_shamt == SHW'(1))) begin
         ld_result  = sh_first[WIDTH-1:0];
         ld_carry   = sh_first[WIDTH];
         ld_ovf     = 1'b0;
         ld_illegal = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         op_r        <= OP_ADD;
         sh_val      <= '0;
         out_valid   <= 1'b0;
         out_result  <= '0;
         out_zero    <= 1'b0;
         out_neg     <= 1'b0;
         out_ovf     <= 1'b0;
         out_carry   <= 1'b0;
         out_illegal <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
         acc         <= '0;
         mcand       <= '0;
`endif
      end else begin
         if (load_out) begin
            out_result  <= ld_result;
            out_zero    <= (ld_result == '0);
            out_neg     <= ld_result[WIDTH-1];
            out_ovf     <= ld_ovf;
            out_carry   <= ld_carry;
            out_illegal <= ld_illegal;
         end
         case (state)
            ST_BUSY: begin
               cnt    <= cnt - CW'(1);
               sh_val <= sh_next[WIDTH-1:0];
`ifdef ALU_SEQ_MUL_EN
               if (op_r == OP_MUL) acc <= mul_next;
`endif
               if (load_out) begin
                  state     <= ST_OUT;
                  out_valid <= 1'b1;
               end
            end
            ST_IDLE, ST_OUT: begin
               if (accept) begin
                  op_r <= in_op;
                  if (start_busy) begin
                     state     <= ST_BUSY;
                     out_valid <= 1'b0;
                     sh_val    <= sh_first[WIDTH-1:0];
                     cnt       <= CW'(in_shamt) - CW'(1);
`ifdef ALU_SEQ_MUL_EN
                     if (in_op == OP_MUL) begin
                        acc   <= mul_first;
                        mcand <= in_a;
                        cnt   <= CW'(WIDTH - 1);
                     end
`endif
                  end else begin
                     state     <= ST_OUT;
                     out_valid <= 1'b1;
                  end
               end else if ((state == ST_OUT) && out_ready) begin
                  state     <= ST_IDLE;
                  out_valid <= 1'b0;
               end
            end
            default: begin
               state     <= ST_IDLE;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=8; expected values hand-computed.
module tb_alu_seq;

   localparam logic [3:0] T_ADD  = 4'b0000;
   localparam logic [3:0] T_SUB  = 4'b0001;
   localparam logic [3:0] T_INC  = 4'b0010;
   localparam logic [3:0] T_MUL  = 4'b0011;
   localparam logic [3:0] T_SEQ  = 4'b0101;
   localparam logic [3:0] T_ASL  = 4'b0110;
   localparam logic [3:0] T_ASR  = 4'b0111;
   localparam logic [3:0] T_NOT  = 4'b1000;
   localparam logic [3:0] T_AND  = 4'b1001;
   localparam logic [3:0] T_OR   = 4'b1010;
   localparam logic [3:0] T_NAND = 4'b1011;
   localparam logic [3:0] T_ROL  = 4'b1100;
   localparam logic [3:0] T_ROR  = 4'b1101;
   localparam logic [3:0] T_ILL  = 4'b1110;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_op;
   logic [7:0] in_a;
   logic [7:0] in_b;
   logic [2:0] in_shamt;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_result;
   logic       out_zero;
   logic       out_neg;
   logic       out_ovf;
   logic       out_carry;
   logic       out_illegal;

   int n_checks = 0;
   int n_pass   = 0;

   alu_seq #(.WIDTH(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_op       (in_op),
      .in_a        (in_a),
      .in_b        (in_b),
      .in_shamt    (in_shamt),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_result  (out_result),
      .out_zero    (out_zero),
      .out_neg     (out_neg),
      .out_ovf     (out_ovf),
      .out_carry   (out_carry),
      .out_illegal (out_illegal)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   task automatic check_res(input string tag, input logic [7:0] res, input logic z,
                            input logic n, input logic o, input logic c, input logic il);
      check({tag, ".valid"},   out_valid,   1);
      check({tag, ".result"},  out_result,  res);
      check({tag, ".zero"},    out_zero,    z);
      check({tag, ".neg"},     out_neg,     n);
      check({tag, ".ovf"},     out_ovf,     o);
      check({tag, ".carry"},   out_carry,   c);
      check({tag, ".illegal"}, out_illegal, il);
   endtask

   // Offers one op, returns edges from accept (inclusive) to out_valid rising.
   task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] sh, output int lat, output logic rdy_after);
      int guard = 0;
      in_valid = 1'b1;
      in_op    = op;
      in_a     = a;
      in_b     = b;
      in_shamt = sh;
      while (in_ready !== 1'b1 && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      @(posedge clk); #1;
      rdy_after = in_ready;
      in_valid  = 1'b0;
      in_op     = 4'hF;
      in_a      = 8'h5A;
      in_b      = 8'hC3;
      in_shamt  = 3'd6;
      lat = 1;
      while (out_valid !== 1'b1 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   initial begin
      int   lat;
      logic rb;
      logic seen;

      rst_n = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0;
      in_shamt = '0; out_ready = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      check("rst.valid",   out_valid,   0);
      check("rst.result",  out_result,  0);
      check("rst.zero",    out_zero,    0);
      check("rst.neg",     out_neg,     0);
      check("rst.ovf",     out_ovf,     0);
      check("rst.carry",   out_carry,   0);
      check("rst.illegal", out_illegal, 0);
      check("rst.ready",   in_ready,    1);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_op(T_ADD, 8'h7F, 8'h01, 3'd0, lat, rb);
      check_res("add_7f_1", 8'h80, 0, 1, 1, 0, 0);
      check("add_7f_1.lat", lat, 1);

      run_op(T_SUB, 8'd20, 8'd50, 3'd0, lat, rb);
      check_res("sub_50_20", 8'd30, 0, 0, 0, 1, 0);

      run_op(T_SUB, 8'd50, 8'd50, 3'd0, lat, rb);
      check_res("sub_50_50", 8'd0, 1, 0, 0, 1, 0);

      run_op(T_INC, 8'hFF, 8'h00, 3'd0, lat, rb);
      check_res("inc_ff", 8'h00, 1, 0, 0, 1, 0);

      run_op(T_SEQ, 8'h05, 8'h05, 3'd0, lat, rb);
      check_res("seq_eq", 8'h01, 0, 0, 0, 0, 0);

      run_op(T_NAND, 8'hFF, 8'h0F, 3'd0, lat, rb);
      check_res("nand", 8'hF0, 0, 1, 0, 0, 0);

      run_op(T_NOT, 8'h0F, 8'h00, 3'd0, lat, rb);
      check_res("not", 8'hF0, 0, 1, 0, 0, 0);

      @(posedge clk); #1;
      run_op(T_ASR, 8'h00, 8'hAA, 3'd3, lat, rb);
      check_res("asr_aa_3", 8'hF5, 0, 1, 0, 0, 0);
      check("asr_aa_3.lat", lat, 3);
      check("asr_aa_3.busy_ready", rb, 0);

      run_op(T_ASL, 8'h00, 8'h81, 3'd2, lat, rb);
      check_res("asl_81_2", 8'h04, 0, 0, 0, 0, 0);
      check("asl_81_2.lat", lat, 2);

      run_op(T_ROL, 8'h81, 8'h00, 3'd0, lat, rb);
      check_res("rol_81_0", 8'h81, 0, 1, 0, 0, 0);
      check("rol_81_0.lat", lat, 1);

      run_op(T_ROL, 8'h81, 8'h00, 3'd1, lat, rb);
      check_res("rol_81_1", 8'h03, 0, 0, 0, 1, 0);
      check("rol_81_1.lat", lat, 1);

      run_op(T_ROR, 8'h01, 8'h00, 3'd1, lat, rb);
      check_res("ror_01_1", 8'h80, 0, 1, 0, 1, 0);

      run_op(T_ILL, 8'h12, 8'h34, 3'd0, lat, rb);
      check_res("illegal_e", 8'h00, 1, 0, 0, 0, 1);
      check("illegal_e.lat", lat, 1);

`ifdef ALU_SEQ_MUL_EN
      run_op(T_MUL, 8'd13, 8'd11, 3'd0, lat, rb);
      check_res("mul_13_11", 8'h8F, 0, 1, 0, 0, 0);
      check("mul_13_11.lat", lat, 8);
      run_op(T_MUL, 8'd12, 8'd30, 3'd0, lat, rb);
      check_res("mul_12_30", 8'h68, 0, 0, 1, 0, 0);
`else
      run_op(T_MUL, 8'd13, 8'd11, 3'd0, lat, rb);
      check_res("mul_absent", 8'h00, 1, 0, 0, 0, 1);
      check("mul_absent.lat", lat, 1);
`endif

      // Backpressure, then back-to-back accept on release
      @(posedge clk); #1;
      out_ready = 1'b0;
      run_op(T_OR, 8'h0F, 8'hF0, 3'd0, lat, rb);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check_res("bp_hold", 8'hFF, 0, 1, 0, 0, 0);
         check("bp_hold.ready", in_ready, 0);
      end
      in_valid = 1'b1; in_op = T_AND; in_a = 8'hCC; in_b = 8'hAA; in_shamt = 3'd0;
      out_ready = 1'b1;
      #1;
      check("bp_release.ready", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check_res("bp_and", 8'h88, 0, 1, 0, 0, 0);

      // Reset in the middle of a shamt=5 shift
      @(posedge clk); #1;
      in_valid = 1'b1; in_op = T_ASL; in_a = 8'h00; in_b = 8'h01; in_shamt = 3'd5;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("rst_mid.busy_ready", in_ready, 0);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      check("rst_mid.valid",   out_valid,   0);
      check("rst_mid.result",  out_result,  0);
      check("rst_mid.zero",    out_zero,    0);
      check("rst_mid.neg",     out_neg,     0);
      check("rst_mid.ovf",     out_ovf,     0);
      check("rst_mid.carry",   out_carry,   0);
      check("rst_mid.illegal", out_illegal, 0);
      check("rst_mid.ready",   in_ready,    1);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1'b1;
      end
      check("rst_mid.no_emit", seen, 0);

      run_op(T_ADD, 8'd10, 8'd5, 3'd0, lat, rb);
      check_res("add_after_rst", 8'd15, 0, 0, 0, 0, 0);
      check("add_after_rst.lat", lat, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
